// File: rtl/alu_arbiter_if.sv
// Request, ALU-drive and response bundle between the requesters, the ALU and alu_arbiter.
// slave is the arbiter's view and master is the requester/consumer/ALU side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic signed [WIDTH-1:0] req_a0;
  logic signed [WIDTH-1:0] req_b0;
  logic [3:0]              req_op0;
  logic signed [WIDTH-1:0] req_a1;
  logic signed [WIDTH-1:0] req_b1;
  logic [3:0]              req_op1;
  logic [WIDTH-1:0]        alu_a;
  logic [WIDTH-1:0]        alu_b;
  logic [3:0]              alu_op;
  logic [WIDTH-1:0]        alu_res;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_id;
  logic [WIDTH-1:0]        rsp_data;
  logic                    rsp_err;

  modport slave (
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
    input  alu_res, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
    output alu_res, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of the shared combinational ALU.
// It has a one-entry response register carrying the requester id and an illegal-opcode flag.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  logic             rr_q, rr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [1:0]       grant_s;
  logic [1:0]       req_ready_s;
  logic             can_accept_s;
  logic             hs_s;
  logic             op_illegal_s;
  logic [WIDTH-1:0] alu_a_s;
  logic [WIDTH-1:0] alu_b_s;
  logic [3:0]       alu_op_s;

  function automatic logic op_illegal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1111: op_illegal = 1'b0;
      default:                                     op_illegal = 1'b1;
    endcase
  endfunction

  // Grant selection: a lone requester wins, and a tie goes to the rr pointer.
  always_comb begin
    grant_s = 2'b00;
    case (bus.req_valid)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = rr_q ? 2'b10 : 2'b01;
      default: grant_s = 2'b00;
    endcase
  end

  // rst_n gates ready so that nothing is accepted while reset is held.
  assign can_accept_s = ~rsp_valid_q | bus.rsp_ready;
  assign req_ready_s  = grant_s & {2{can_accept_s & rst_n}};
  assign hs_s         = |req_ready_s;

  // ALU drive follows the grant alone, which keeps rsp_ready off the alu_* paths.
  always_comb begin
    alu_a_s  = {WIDTH{1'b0}};
    alu_b_s  = {WIDTH{1'b0}};
    alu_op_s = 4'b0000;
    case (grant_s)
      2'b01: begin
        alu_a_s  = bus.req_a0;
        alu_b_s  = bus.req_b0;
        alu_op_s = bus.req_op0;
      end
      2'b10: begin
        alu_a_s  = bus.req_a1;
        alu_b_s  = bus.req_b1;
        alu_op_s = bus.req_op1;
      end
      default: begin
        alu_a_s  = {WIDTH{1'b0}};
        alu_b_s  = {WIDTH{1'b0}};
        alu_op_s = 4'b0000;
      end
    endcase
  end

  assign op_illegal_s = op_illegal(alu_op_s);

  // Response register and rr next state.
  always_comb begin
    rr_d        = rr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    if (hs_s) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = req_ready_s[1];
      rsp_err_d   = op_illegal_s;
      rsp_data_d  = op_illegal_s ? {WIDTH{1'b0}} : bus.alu_res;
      rr_d        = ~req_ready_s[1];
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= {WIDTH{1'b0}};
    end else begin
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.alu_a     = alu_a_s;
  assign bus.alu_b     = alu_b_s;
  assign bus.alu_op    = alu_op_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed test of alu_arbiter with hand-computed expectations.
// A small behavioural ALU answers the arbiter's operand and opcode lines.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; illegal codes return garbage so the arbiter's zeroing is visible.
  always_comb begin
    case (bus.alu_op)
      4'b0000: bus.alu_res = bus.alu_a + bus.alu_b;
      4'b1000: bus.alu_res = bus.alu_a - bus.alu_b;
      4'b0001: bus.alu_res = bus.alu_a << bus.alu_b[4:0];
      4'b0010: bus.alu_res = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      4'b0011: bus.alu_res = {31'd0, bus.alu_a < bus.alu_b};
      4'b0100: bus.alu_res = bus.alu_a ^ bus.alu_b;
      4'b0101: bus.alu_res = bus.alu_a >> bus.alu_b[4:0];
      4'b1101: bus.alu_res = $signed(bus.alu_a) >>> bus.alu_b[4:0];
      4'b0110: bus.alu_res = bus.alu_a | bus.alu_b;
      4'b0111: bus.alu_res = bus.alu_a & bus.alu_b;
      4'b1111: bus.alu_res = bus.alu_b;
      default: bus.alu_res = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic id,
                         input logic [31:0] data, input logic err);
    chk({tag, ".valid"}, {31'd0, bus.rsp_valid}, {31'd0, v});
    chk({tag, ".id"},    {31'd0, bus.rsp_id},    {31'd0, id});
    chk({tag, ".data"},  bus.rsp_data,           data);
    chk({tag, ".err"},   {31'd0, bus.rsp_err},   {31'd0, err});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_a0 = 32'sd0;  bus.req_b0 = 32'sd0;  bus.req_op0 = 4'b0000;
    bus.req_a1 = 32'sd0;  bus.req_b1 = 32'sd0;  bus.req_op1 = 4'b0000;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    chk_rsp("reset", 1'b0, 1'b0, 32'd0, 1'b0);
    chk("reset.ready", {30'd0, bus.req_ready}, 32'd0);

    // Port 0 add 5+7.
    rst_n = 1'b1;
    bus.req_valid = 2'b01;
    bus.req_a0 = 32'sd5;  bus.req_b0 = 32'sd7;  bus.req_op0 = 4'b0000;
    #1;
    chk("add.ready", {30'd0, bus.req_ready}, 32'd1);
    chk("add.alu_a", bus.alu_a, 32'd5);
    chk("add.alu_b", bus.alu_b, 32'd7);
    chk_rsp("add.pre", 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    chk_rsp("add", 1'b1, 1'b0, 32'd12, 1'b0);

    // Port 1 xor, then a response stall with port 0 waiting.
    bus.req_valid = 2'b10;
    bus.req_a1 = 32'sh0F0;  bus.req_b1 = 32'sh0FF;  bus.req_op1 = 4'b0100;
    #1;
    chk("xor.ready", {30'd0, bus.req_ready}, 32'd2);
    tick();
    chk_rsp("xor", 1'b1, 1'b1, 32'h0000_000F, 1'b0);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_a0 = 32'sd2;  bus.req_b0 = 32'sd3;  bus.req_op0 = 4'b0000;
    #1;
    chk("stall.ready", {30'd0, bus.req_ready}, 32'd0);
    chk("stall.alu_a", bus.alu_a, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.ready_hold", {30'd0, bus.req_ready}, 32'd0);
      chk_rsp("stall.hold", 1'b1, 1'b1, 32'h0000_000F, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("unstall.ready", {30'd0, bus.req_ready}, 32'd1);
    tick();
    chk_rsp("unstall", 1'b1, 1'b0, 32'd5, 1'b0);

    // Illegal opcode, then sltu 1 < 0xFFFFFFFF.
    bus.req_a0 = 32'sd9;  bus.req_b0 = 32'sd9;  bus.req_op0 = 4'b1010;
    tick();
    chk_rsp("illegal", 1'b1, 1'b0, 32'd0, 1'b1);
    bus.req_a0 = 32'sd1;  bus.req_b0 = -32'sd1;  bus.req_op0 = 4'b0011;
    tick();
    chk_rsp("sltu", 1'b1, 1'b0, 32'd1, 1'b0);

    // Idle cycle drains the response.
    bus.req_valid = 2'b00;
    #1;
    chk("idle.alu_op", {28'd0, bus.alu_op}, 32'd0);
    chk("idle.alu_a", bus.alu_a, 32'd0);
    chk("idle.alu_b", bus.alu_b, 32'd0);
    chk("idle.ready", {30'd0, bus.req_ready}, 32'd0);
    tick();
    chk_rsp("drain", 1'b0, 1'b0, 32'd1, 1'b0);

    // Reset asserted while a response is held and both ports request.
    bus.req_valid = 2'b01;
    bus.req_a0 = 32'sd1;  bus.req_b0 = 32'sd1;  bus.req_op0 = 4'b0000;
    tick();
    chk_rsp("prereset", 1'b1, 1'b0, 32'd2, 1'b0);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_a0 = 32'sd10;  bus.req_b0 = 32'sd3;   bus.req_op0 = 4'b1000;
    bus.req_a1 = -32'sd8;  bus.req_b1 = 32'sd1;   bus.req_op1 = 4'b1101;
    #1;
    chk("bp.ready", {30'd0, bus.req_ready}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_rsp("async_rst", 1'b0, 1'b0, 32'd0, 1'b0);
    chk("async_rst.ready", {30'd0, bus.req_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;

    // Continuous tie alternates 0,1,0,1 starting from port 0.
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt.ready", {30'd0, bus.req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      if (i % 2 == 0) chk_rsp("alt.sub", 1'b1, 1'b0, 32'd7, 1'b0);
      else            chk_rsp("alt.sra", 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    end
    #1;
    chk("alt.rr_after", {30'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter that shares the single combinational ALU between the execute stage (port 0) and a secondary requester (port 1, address generation / debug). It accepts one operation per cycle over valid/ready, drives the ALU operand and opcode lines from the granted request, and captures the result in a one-entry response register with requester tag and illegal-opcode flag. It sits between the requesters and the ALU instance, and is the only driver of the ALU inputs.

## Interface
- WIDTH, 32, operand/result width; matches the ALU datapath.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_ready  out  2  per-port accept; handshake on req_valid[i] & req_ready[i].
- req_a0, req_b0  in  WIDTH each  port 0 operands (signed).
- req_op0  in  4  port 0 ALU opcode.
- req_a1, req_b1  in  WIDTH each  port 1 operands (signed).
- req_op1  in  4  port 1 ALU opcode.
- alu_a, alu_b  out  WIDTH each  ALU operands.
- alu_op  out  4  ALU opcode.
- alu_res  in  WIDTH  ALU combinational result.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  port that issued the response.
- rsp_data  out  WIDTH  registered result.
- rsp_err  out  1  opcode was illegal.

## Operation
- Legal opcodes: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and, 1111 pass-B. All other codes illegal.
- State: rr pointer (1 bit, port with priority), response register {rsp_valid, rsp_id, rsp_data, rsp_err}.
- can_accept = ~rsp_valid | rsp_ready.
- Grant (combinational): only one valid -> that port; both valid -> port rr; none -> no grant.
- req_ready[i] = grant[i] & can_accept; at most one bit set per cycle. Ready depends on valid; requesters must not make valid depend on ready and must hold operands/opcode stable while valid & ~ready.
- ALU drive: granted port's a/b/op, regardless of can_accept. No grant -> alu_a=0, alu_b=0, alu_op=0000.
- On handshake from port g: rsp_valid<=1, rsp_id<=g, rsp_err<=illegal(op), rsp_data<= illegal ? 0 : alu_res; rr<=~g.
- rr updates only on a handshake; a stalled grant does not rotate priority.
- No handshake and rsp_valid & rsp_ready: rsp_valid<=0; rsp_data/rsp_id/rsp_err hold last values.
- Handshake and response drain in same cycle: new result replaces old, rsp_valid stays 1 (full throughput).
- Results pass unmodified; width rules (slt/sltu 0/1 in bit 0, shift amount interpretation) are the ALU's.

## Timing
- Reset (async assert, sync release on next clk edge after rst_n high): rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, rr=0 (port 0 wins first tie). req_ready and ALU drive follow combinationally (req_ready can rise as soon as reset is released).
- Latency: request accepted in cycle T -> rsp_valid=1 with result in T+1.
- Throughput: one op per cycle while rsp_ready=1; both ports continuously valid -> strict alternation 0,1,0,1...
- Backpressure: rsp_valid & ~rsp_ready -> req_ready=00; response register and rr frozen.
- Reset mid-operation: in-flight response discarded, rsp_valid=0 immediately on rst_n low; pending requests not accepted while rst_n=0.
- No combinational path from rsp_ready to alu_* outputs; path rsp_ready -> req_ready is allowed.

## Test plan
- Reset then port 0 only, add a=5 b=7, rsp_ready=1 -> req_ready=01 in T, T+1 rsp_valid=1, rsp_id=0, rsp_data=12, rsp_err=0.
- Both ports valid 4 cycles, port 0 sub 10-3, port 1 sra -8>>>1 -> grants 0,1,0,1; responses 7,-4,7,-4 with ids 0,1,0,1; rr=0 after.
- Response stall: accept port 1 xor 0xF0^0xFF, hold rsp_ready=0 3 cycles with port 0 valid -> req_ready=00, rsp_data=0x0F stable; on rsp_ready=1 port 0 accepted same cycle, next result follows in following cycle.
- Illegal opcode 1010 on port 0 -> rsp_err=1, rsp_data=0; next legal op (sltu a=1 b=-1) -> rsp_err=0, rsp_data=1.
- Idle cycle -> alu_op=0000, alu_a=alu_b=0, rsp_valid drops after drain.
- Assert rst_n=0 while rsp_valid=1 and both ports valid -> rsp_valid=0 asynchronously, req_ready=00; after release first tie goes to port 0.
